// File: rtl/conv_mode_scheduler_if.sv
// Requester/datapath handshake bundle for the shared convolution datapath scheduler.
interface conv_mode_scheduler_if;
    logic conv_req;
    logic conv_done;
    logic transconv_req;
    logic transconv_done;
    logic err_clr;
    logic conv_grant;
    logic transconv_grant;
    logic conv_mode;
    logic clear_all;
    logic busy;
    logic err_timeout;

    modport master (
        output conv_req, conv_done, transconv_req, transconv_done, err_clr,
        input  conv_grant, transconv_grant, conv_mode, clear_all, busy, err_timeout
    );

    modport slave (
        input  conv_req, conv_done, transconv_req, transconv_done, err_clr,
        output conv_grant, transconv_grant, conv_mode, clear_all, busy, err_timeout
    );
endinterface

// File: rtl/conv_mode_scheduler.sv
// Round-robin owner of the unified conv datapath: arbitrates 1DCONV vs TRANSCONV,
// sequences clear/settle before each job, drain after it, and watchdogs the grant.
module conv_mode_scheduler #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES  = 4,
    parameter int unsigned TIMEOUT       = 65536,
    parameter int unsigned CW            = 17
) (
    input logic                  clk,
    input logic                  rst_n,
    conv_mode_scheduler_if.slave bus
);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD  = (DRAIN_CYCLES == 0) ? '0 : CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_W   = CW'(TIMEOUT);
    localparam logic          WDOG_EN     = (TIMEOUT != 0);
    localparam logic          OWN_CONV    = 1'b0;
    localparam logic          OWN_TRANS   = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_SWITCH, ST_GRANT, ST_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic          mode_q, mode_d;
    logic          conv_grant_q, conv_grant_d;
    logic          trans_grant_q, trans_grant_d;
    logic          clear_q, clear_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic win_any_c, win_sel_c, owner_done_c, timed_out_c, err_set_c;

    // Tie goes to whichever requester did not own the previous job
    assign win_any_c    = bus.conv_req | bus.transconv_req;
    assign win_sel_c    = bus.transconv_req & (~bus.conv_req | (last_owner_q == OWN_CONV));
    assign owner_done_c = (owner_q == OWN_TRANS) ? bus.transconv_done : bus.conv_done;
    assign timed_out_c  = WDOG_EN & ((cnt_q + CW'(1)) == TIMEOUT_W);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        mode_d        = mode_q;
        conv_grant_d  = conv_grant_q;
        trans_grant_d = trans_grant_q;
        clear_d       = 1'b0;
        busy_d        = busy_q;
        err_set_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (win_any_c) begin
                    owner_d = win_sel_c;
                    mode_d  = win_sel_c;
                    clear_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = (win_sel_c != mode_q) ? SETTLE_LOAD : '0;
                    state_d = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                if (cnt_q == '0) begin
                    conv_grant_d  = (owner_q == OWN_CONV);
                    trans_grant_d = (owner_q == OWN_TRANS);
                    state_d       = ST_GRANT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GRANT: begin
                // Owner completion outranks a watchdog expiry on the same edge
                if (owner_done_c || timed_out_c) begin
                    err_set_c     = ~owner_done_c;
                    conv_grant_d  = 1'b0;
                    trans_grant_d = 1'b0;
                    last_owner_d  = owner_q;
                    cnt_d         = DRAIN_LOAD;
                    if (DRAIN_CYCLES == 0) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        err_d = err_set_c | (err_q & ~bus.err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            owner_q       <= OWN_CONV;
            last_owner_q  <= OWN_TRANS;
            mode_q        <= 1'b0;
            conv_grant_q  <= 1'b0;
            trans_grant_q <= 1'b0;
            clear_q       <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            mode_q        <= mode_d;
            conv_grant_q  <= conv_grant_d;
            trans_grant_q <= trans_grant_d;
            clear_q       <= clear_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
        end
    end

    assign bus.conv_grant      = conv_grant_q;
    assign bus.transconv_grant = trans_grant_q;
    assign bus.conv_mode       = mode_q;
    assign bus.clear_all       = clear_q;
    assign bus.busy            = busy_q;
    assign bus.err_timeout     = err_q;
endmodule

// File: doc/conv_mode_scheduler.md
# conv_mode_scheduler

Time-multiplexes the shared unified convolution datapath (buffers plus systolic array) between two job requesters: the 1D-convolution control path and the transposed-convolution control path. It arbitrates round-robin and owns the `conv_mode` select into the datapath. Before each job it sequences a psum-clear pulse and a settle window. After each job it enforces a drain window. A watchdog aborts any job that never signals completion. It sits between the two control tops and the convolution top, and is the only driver of `conv_mode`.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: length of the SWITCH window when `conv_mode` changes. Must be ≥1.
- `DRAIN_CYCLES`, default 4: idle cycles after job completion before the next arbitration. 0 is legal.
- `TIMEOUT`, default 65536: maximum GRANT cycles without `done`. 0 disables the watchdog.
- `CW`, default 17: counter width. Must hold max(`SETTLE_CYCLES`, `DRAIN_CYCLES`, `TIMEOUT`).

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `conv_req` in 1: 1DCONV job request (level). Hold until `conv_grant`.
- `conv_done` in 1: 1DCONV job-complete pulse. Honoured only while `conv_grant`=1.
- `transconv_req` in 1: TRANSCONV job request (level).
- `transconv_done` in 1: TRANSCONV job-complete pulse. Honoured only while `transconv_grant`=1.
- `err_clr` in 1: clears `err_timeout`.
- `conv_grant` out 1: 1DCONV owns the datapath.
- `transconv_grant` out 1: TRANSCONV owns the datapath.
- `conv_mode` out 1: datapath select (0 = 1DCONV, 1 = TRANSCONV).
- `clear_all` out 1: one-cycle pulse to drive all psum-clear controls.
- `busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: sticky watchdog flag.

## Operation
- FSM states: IDLE → SWITCH → GRANT → DRAIN → IDLE. All outputs are registered.
- **IDLE, arbitration:**
  - If exactly one request is high, that requester wins.
  - If both are high, the requester that was NOT the last owner wins. `last_owner` resets to TRANSCONV, so 1DCONV wins the first tie.
  - On a winner: latch `owner`, set `conv_mode` (0 for 1DCONV, 1 for TRANSCONV), pulse `clear_all`, load the counter, go to SWITCH.
  - With no request, stay in IDLE.
- **SWITCH:**
  - Length is `SETTLE_CYCLES` cycles if `conv_mode` changed value, otherwise 1 cycle.
  - `clear_all` is high only during the first SWITCH cycle.
  - At the end of the window: assert the owner's grant and go to GRANT.
  - The arbitration decision is committed: dropping `req` during SWITCH does not cancel the grant.
- **GRANT:**
  - The watchdog counter increments each cycle.
  - On the owner's `done`: drop the grant, update `last_owner`, go to DRAIN.
  - The non-owner's `done` is ignored.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` without `done`: set `err_timeout`, drop the grant, update `last_owner`, go to DRAIN.
- **DRAIN:**
  - Lasts `DRAIN_CYCLES` cycles, then IDLE. With `DRAIN_CYCLES`=0, go from GRANT directly to IDLE.
  - `conv_mode` holds its value through DRAIN and IDLE. It changes only on entry to SWITCH.
- **`err_timeout`:**
  - Set by a timeout event; cleared by `err_clr`.
  - If set and clear occur in the same cycle, set wins.
  - It does not block further scheduling.
- **Invariant:** at most one grant is high at any time, and a grant is never high outside GRANT.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0): state=IDLE, `conv_mode`=0, both grants=0, `clear_all`=0, `busy`=0, `err_timeout`=0, counter=0, `last_owner`=TRANSCONV.
- Reset asserted mid-job returns all outputs to their reset values without waiting for `done` or the drain window.
- Latency with `req` sampled high at edge k:
  - `clear_all`=1 and `busy`=1 are visible from edge k.
  - The grant rises at edge k+`SETTLE_CYCLES` on a mode change, or at edge k+1 with no mode change.
- `done` sampled at edge m: the grant is low from edge m, and `busy` is low from edge m+`DRAIN_CYCLES`.
- With a request held, the earliest re-arbitration is the first IDLE edge, i.e. m+`DRAIN_CYCLES`+1.
- A `done` that coincides with the timeout edge is treated as normal completion: `err_timeout` is not set.
- Minimum grant length is 1 cycle: `done` is legal on the first GRANT cycle.

## Test plan
Parameters for all cases: `SETTLE_CYCLES`=4, `DRAIN_CYCLES`=4, `TIMEOUT`=100.
- Reset, then `transconv_req`=1 at edge 2 → `conv_mode`=1 and `clear_all` 1-cycle pulse at edge 2; `transconv_grant`=1 at edge 6. `done` at edge 20 → grant low at edge 20, `busy` low at edge 24.
- Back-to-back 1DCONV jobs with only `conv_req` held → each new job has `clear_all` and then the grant 1 cycle later (no mode change); `conv_mode` stays 0 throughout.
- Both requests held continuously → grants alternate 1DCONV, TRANSCONV, 1DCONV starting with 1DCONV; `conv_mode` toggles; `conv_grant` and `transconv_grant` are never both 1.
- Owner never asserts `done` → grant drops after 100 GRANT cycles; `err_timeout`=1 stays set through the next job; `err_clr` pulse → 0. Same-cycle set and clear → stays 1.
- Non-owner `done` during GRANT, and owner `done` during SWITCH/DRAIN → no state effect.
- `rst_n` pulsed low mid-GRANT with `conv_mode`=1 → grant=0, `conv_mode`=0, `busy`=0 immediately; after release with no requests the block stays in IDLE.
